// File: rtl/pe_pkg.sv
// Shared types and constants for the float MAC PE driver.
package pe_pkg;

  localparam int L_RAM_SIZE_DEF = 4;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // state    | meaning
  // IDLE     | waiting for start
  // CLEAR    | PE held in reset to flush accumulator and FMA pipeline
  // LOAD     | host words written into PE RAM (B vector)
  // FETCH    | next A word taken from host, RAM address settling
  // ISSUE    | operand pulse to the PE
  // WAIT     | single operation in flight, waiting for pe_dvalid
  // RESULT   | dot product presented until accepted
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_e;

endpackage

// File: rtl/pe_mac_driver.sv
// Sequences one float MAC PE: loads the B vector into PE RAM, then streams
// A operands one at a time and returns the accumulated dot product.
module pe_mac_driver
  import pe_pkg::*;
#(
  parameter int          L_RAM_SIZE = L_RAM_SIZE_DEF,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [31:0]           s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           m_tdata,
  output logic                  busy,
  output logic                  err,
  output logic                  pe_aresetn,
  output logic [31:0]           pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [31:0]           pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [L_RAM_SIZE:0] LEN_MAX = {1'b1, {L_RAM_SIZE{1'b0}}};

  state_e                state_q, state_d;
  logic [L_RAM_SIZE:0]   len_q, len_d;
  logic [L_RAM_SIZE:0]   idx_q, idx_d;
  logic [CW-1:0]         clr_q, clr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [31:0]           m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  busy_q, busy_d;
  logic                  pe_aresetn_q, pe_aresetn_d;
  logic [31:0]           pe_din_q, pe_din_d;
  logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
  logic                  pe_we_q, pe_we_d;
  logic [31:0]           pe_ain_q, pe_ain_d;
  logic                  pe_valid_q, pe_valid_d;
  logic                  last_elem;

  assign last_elem = (idx_q == len_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    m_tdata_d = m_tdata_q;
    pe_din_d  = pe_din_q;
    pe_addr_d = pe_addr_q;
    pe_ain_d  = pe_ain_q;
    pe_we_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = (len > LEN_MAX) ? LEN_MAX : len;
          idx_d     = '0;
          err_d     = 1'b0;
          m_tdata_d = FP_ZERO;
          if (len == '0) begin
            state_d = S_RESULT;
          end else begin
            clr_d   = CW'(CLR_CYCLES - 1);
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        if (clr_q == '0) state_d = S_LOAD;
        else clr_d = clr_q - 1'b1;
      end
      S_LOAD: begin
        if (s_tvalid) begin
          pe_we_d   = 1'b1;
          pe_din_d  = s_tdata;
          pe_addr_d = idx_q[L_RAM_SIZE-1:0];
          if (last_elem) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        pe_addr_d = idx_q[L_RAM_SIZE-1:0];
        if (s_tvalid) begin
          pe_ain_d = s_tdata;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TW'(TIMEOUT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_dvalid) begin
          m_tdata_d = pe_dout;
          idx_d     = idx_q + 1'b1;
          state_d   = last_elem ? S_RESULT : S_FETCH;
        end else if (TIMEOUT != 0 && tmo_q == '0) begin
          err_d     = 1'b1;
          m_tdata_d = FP_QNAN;
          state_d   = S_RESULT;
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_RESULT: begin
        if (m_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    m_tvalid_d   = (state_d == S_RESULT);
    busy_d       = (state_d != S_IDLE);
    pe_aresetn_d = (state_d != S_CLEAR);
    // Operand pulse trails ISSUE by a cycle so the RAM read of pe_addr has landed.
    pe_valid_d   = (state_q == S_ISSUE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      clr_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      busy_q       <= 1'b0;
      pe_aresetn_q <= 1'b0;
      pe_din_q     <= '0;
      pe_addr_q    <= '0;
      pe_we_q      <= 1'b0;
      pe_ain_q     <= '0;
      pe_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      clr_q        <= clr_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      busy_q       <= busy_d;
      pe_aresetn_q <= pe_aresetn_d;
      pe_din_q     <= pe_din_d;
      pe_addr_q    <= pe_addr_d;
      pe_we_q      <= pe_we_d;
      pe_ain_q     <= pe_ain_d;
      pe_valid_q   <= pe_valid_d;
    end
  end

  assign s_tready   = (state_q == S_LOAD) || (state_q == S_FETCH);
  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign pe_aresetn = pe_aresetn_q;
  assign pe_din     = pe_din_q;
  assign pe_addr    = pe_addr_q;
  assign pe_we      = pe_we_q;
  assign pe_ain     = pe_ain_q;
  assign pe_valid   = pe_valid_q;

endmodule

// File: tb/tb_pe_mac_driver.sv
// Bench for pe_mac_driver with a behavioural float MAC PE and an integer dot-product reference.
module tb_pe_mac_driver;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic        busy, err, pe_aresetn, pe_we, pe_valid;
  logic [31:0] pe_din, pe_ain;
  logic [3:0]  pe_addr;
  logic        pe_dvalid = 1'b0;
  logic [31:0] pe_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  pe_mac_driver #(.L_RAM_SIZE(4), .CLR_CYCLES(2), .TIMEOUT(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .len(len),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .busy(busy), .err(err), .pe_aresetn(pe_aresetn),
    .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_ain(pe_ain), .pe_valid(pe_valid),
    .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  function automatic logic [31:0] int2sp(input int n);
    int p;
    logic [31:0] sh;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (n[i]) p = i;
    sh = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  function automatic real sp2real(input logic [31:0] x);
    int e;
    logic [63:0] d;
    if (x[30:0] == 31'h0) return 0.0;
    e = int'(x[30:23]) - 127 + 1023;
    d = {x[31], 11'(e), x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  // Behavioural PE: RAM with 1-cycle read, FMA with 3-cycle latency.
  logic [31:0] pe_ram [16];
  logic [31:0] b_rd = '0;
  bit          pe_stub = 1'b0;
  real         acc = 0.0;
  real         pend_val = 0.0;
  int          pend = 0;

  always @(posedge aclk) begin
    pe_dvalid <= 1'b0;
    if (pe_we) pe_ram[pe_addr] <= pe_din;
    b_rd <= pe_ram[pe_addr];
    if (!pe_aresetn) begin
      acc  = 0.0;
      pend = 0;
    end else begin
      if (pend == 1) begin
        acc = pend_val;
        if (!pe_stub) begin
          pe_dvalid <= 1'b1;
          pe_dout   <= real2sp(acc);
        end
      end
      if (pend > 0) pend = pend - 1;
      if (pe_valid) begin
        pend_val = acc + sp2real(pe_ain) * sp2real(b_rd);
        pend     = 3;
      end
    end
  end

  int n_valid_tot = 0;
  int n_we_tot = 0;
  int we_log [0:1023];
  int clr_run = 0;
  int last_clr_run = 0;

  always @(posedge aclk) begin
    if (pe_valid) n_valid_tot <= n_valid_tot + 1;
    if (pe_we) begin
      we_log[n_we_tot] <= int'(pe_addr);
      n_we_tot         <= n_we_tot + 1;
    end
    if (aresetn && !pe_aresetn) clr_run <= clr_run + 1;
    else if (pe_aresetn && clr_run != 0) begin
      last_clr_run <= clr_run;
      clr_run      <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] b_vec [16];
  logic [31:0] a_vec [16];
  int          b_int [16];
  int          a_int [16];

  task automatic feed_word(input logic [31:0] w, input int gap_max);
    int k;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = w;
    k = 0;
    while (!s_tready && k < 100) begin
      @(negedge aclk);
      k++;
    end
    chk("feed_tready", 32'(s_tready), 32'd1);
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  task automatic run_job(input string tag, input int len_in, input int gap_max, input int hold,
                         input logic [31:0] exp_res, input logic exp_err, output int lat);
    int eff, base_we, base_v, k;
    bit ok;
    eff     = (len_in > 16) ? 16 : len_in;
    base_we = n_we_tot;
    base_v  = n_valid_tot;
    start = 1'b1;
    len   = 5'(len_in);
    @(negedge aclk);
    start = 1'b0;
    for (int i = 0; i < 2 * eff; i++)
      feed_word((i < eff) ? b_vec[i] : a_vec[i - eff], gap_max);
    k = 0;
    while (!m_tvalid && k < 400) begin
      @(negedge aclk);
      k++;
    end
    lat = k;
    chk({tag, "_mvalid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_mdata"}, m_tdata, exp_res);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_no_extra"}, 32'(s_tready), 32'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge aclk);
      chk({tag, "_hold_valid"}, 32'(m_tvalid), 32'd1);
      chk({tag, "_hold_data"}, m_tdata, exp_res);
    end
    m_tready = 1'b1;
    @(negedge aclk);
    m_tready = 1'b0;
    chk({tag, "_mvalid_drop"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_we_count"}, 32'(n_we_tot - base_we), 32'(eff));
    chk({tag, "_valid_count"}, 32'(n_valid_tot - base_v), 32'(eff));
    ok = 1'b1;
    for (int i = 0; i < eff; i++) if (we_log[base_we + i] != i) ok = 1'b0;
    chk({tag, "_we_addr"}, 32'(ok), 32'd1);
    if (eff > 0) chk({tag, "_clr_cycles"}, 32'(last_clr_run), 32'd2);
  endtask

  function automatic logic [31:0] ref_dot(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += b_int[i] * a_int[i];
    return int2sp(s);
  endfunction

  task automatic randomize_vecs();
    for (int i = 0; i < 16; i++) begin
      b_int[i] = int'($urandom_range(0, 15));
      a_int[i] = int'($urandom_range(0, 15));
      b_vec[i] = int2sp(b_int[i]);
      a_vec[i] = int2sp(a_int[i]);
    end
  endtask

  initial begin
    int lat, n;

    repeat (3) @(negedge aclk);
    chk("rst_ctl", 32'({s_tready, m_tvalid, pe_we, pe_valid, busy, err, pe_aresetn}), 32'd0);
    chk("rst_mdata", m_tdata, 32'h0);
    chk("rst_pe_data", pe_din | pe_ain, 32'h0);
    chk("rst_addr", 32'(pe_addr), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    b_vec[0] = 32'h3F80_0000; b_vec[1] = 32'h4000_0000;
    a_vec[0] = 32'h4040_0000; a_vec[1] = 32'h4080_0000;
    run_job("dir1", 2, 0, 0, 32'h4130_0000, 1'b0, lat);
    run_job("dir2", 2, 0, 0, 32'h4130_0000, 1'b0, lat);

    run_job("len0", 0, 0, 0, 32'h0, 1'b0, lat);
    chk("len0_latency", 32'(lat <= 1), 32'd1);

    for (int j = 0; j < 5; j++) begin
      randomize_vecs();
      n = int'($urandom_range(1, 16));
      run_job("rand", n, 3, (j == 1) ? 10 : 0, ref_dot(n), 1'b0, lat);
    end

    randomize_vecs();
    run_job("sat", 20, 1, 0, ref_dot(16), 1'b0, lat);

    pe_stub = 1'b1;
    run_job("tmo", 1, 0, 0, 32'h7FC0_0000, 1'b1, lat);
    chk("tmo_latency", 32'(lat), 32'd10);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    pe_stub = 1'b0;

    randomize_vecs();
    run_job("after_tmo", 3, 0, 0, ref_dot(3), 1'b0, lat);

    pe_stub = 1'b1;
    start = 1'b1;
    len   = 5'd2;
    @(negedge aclk);
    start = 1'b0;
    feed_word(b_vec[0], 0);
    feed_word(b_vec[1], 0);
    feed_word(a_vec[0], 0);
    repeat (3) @(negedge aclk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("abort_ctl", 32'({s_tready, m_tvalid, pe_we, pe_valid, busy, err, pe_aresetn}), 32'd0);
    chk("abort_mdata", m_tdata, 32'h0);
    chk("abort_pe_data", pe_din | pe_ain, 32'h0);
    chk("abort_addr", 32'(pe_addr), 32'd0);
    aresetn = 1'b1;
    pe_stub = 1'b0;
    repeat (3) @(negedge aclk);
    chk("abort_no_result", 32'({m_tvalid, busy}), 32'd0);

    randomize_vecs();
    run_job("post_rst", 4, 2, 0, ref_dot(4), 1'b0, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_driver.md
Name: pe_mac_driver

Overview:
- Sequencer that drives one float multiply-accumulate PE (local B-vector RAM plus a float fused multiply-add whose accumulator feeds back from its own output).
- Accepts one 32-bit word stream from the host and computes a dot product:
  - first LEN words are written into the PE RAM (B vector);
  - next LEN words are issued one at a time on the PE's A port.
- Returns the final accumulated float on a valid/ready result port.
- Sits between the host DMA stream and each PE instance.

Parameters:
- L_RAM_SIZE, 4, PE RAM address width; vector length 1..2**L_RAM_SIZE.
- CLR_CYCLES, 2, cycles pe_aresetn is held low to clear the PE accumulator and FMA pipeline (minimum 2).
- TIMEOUT, 255, max cycles in WAIT for pe_dvalid before error; 0 disables.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- len  in  L_RAM_SIZE+1  vector length, sampled on start.
- s_tvalid  in  1  host word valid.
- s_tready  out  1  driver accepts word.
- s_tdata  in  32  host word (IEEE-754 single).
- m_tvalid  out  1  result valid.
- m_tready  in  1  result accepted.
- m_tdata  out  32  dot-product result.
- busy  out  1  job in progress (state != IDLE).
- err  out  1  sticky timeout flag, cleared on start.
- pe_aresetn  out  1  PE reset; low when aresetn low or in CLEAR; registered.
- pe_din  out  32  PE RAM write data.
- pe_addr  out  L_RAM_SIZE  PE RAM address.
- pe_we  out  1  PE RAM write enable.
- pe_ain  out  32  PE A operand.
- pe_valid  out  1  PE operand valid (one-cycle pulse).
- pe_dvalid  in  1  PE result valid.
- pe_dout  in  32  PE result.

Behaviour:
- Reset: aresetn low (synchronous, active-low, clock aclk) puts the FSM in IDLE. Under reset:
  - s_tready, m_tvalid, pe_we, pe_valid, busy, err = 0;
  - m_tdata, pe_din, pe_ain, pe_addr, idx = 0;
  - pe_aresetn = 0.
- Reset mid-job aborts the job with no partial result.
- States: IDLE, CLEAR, LOAD, FETCH, ISSUE, WAIT, RESULT.
- IDLE:
  - start latches len; len > 2**L_RAM_SIZE saturates to 2**L_RAM_SIZE.
  - len==0 -> RESULT with m_tdata=0x00000000 and no PE activity.
  - otherwise -> CLEAR, idx=0, err cleared.
  - start while busy is ignored.
- CLEAR: pe_aresetn low for exactly CLR_CYCLES cycles, then -> LOAD.
- LOAD:
  - s_tready=1. On handshake: pe_we=1, pe_din=s_tdata, pe_addr=idx (registered, same cycle as write); idx++.
  - After the len-th word: idx=0 -> FETCH.
  - pe_we is 0 in every other state.
- FETCH:
  - pe_addr=idx held stable; s_tready=1.
  - On handshake, latch pe_ain=s_tdata -> ISSUE.
  - The PE RAM read latency of 1 is covered because addr is stable at least one edge before ISSUE.
- ISSUE: pe_valid=1 for exactly one cycle -> WAIT.
- WAIT:
  - Hold pe_addr and pe_ain; s_tready=0.
  - Only one operation is ever in flight, so the PE accumulator feedback is always current.
  - On pe_dvalid: capture pe_dout into m_tdata, idx++. If idx==len-1 (last element) -> RESULT, else -> FETCH.
  - Timeout: counter exceeds TIMEOUT -> err=1, m_tdata=0x7FC00000 (qNaN) -> RESULT.
  - pe_dvalid outside WAIT is ignored.
- RESULT:
  - m_tvalid=1, m_tdata stable until m_tready; on handshake -> IDLE.
  - m_tvalid never drops without a handshake.
- s_tvalid stalls at any point simply extend LOAD/FETCH; no timeout applies there.
- Host stream words beyond 2*len are not consumed.

Decomposition:
- Shared package pe_pkg holds:
  - state enum;
  - FP_ZERO=32'h00000000 and FP_QNAN=32'h7FC00000 constants;
  - L_RAM_SIZE default.
- No sub-module required; the WAIT timeout counter is inline.
- The bench instantiates pe_mac_driver with the existing PE.

Test Plan:
- len=2, stream B=[0x3F800000, 0x40000000], A=[0x40400000, 0x40800000] -> m_tdata=0x41300000 (11.0); exactly 2 pe_valid pulses; pe_we asserted for addr 0,1.
- Back-to-back jobs with the same data -> second result is also 0x41300000; the accumulator is cleared via pe_aresetn low for exactly 2 cycles.
- len=0 -> m_tvalid within 2 cycles, m_tdata=0; no pe_we or pe_valid.
- Random s_tvalid gaps plus m_tready held low 10 cycles -> result unchanged; m_tvalid stays high until accepted.
- pe_dvalid forced low (stub PE), TIMEOUT=8 -> err=1, m_tdata=0x7FC00000 after 9 WAIT cycles.
- aresetn asserted during WAIT -> next cycle all outputs at reset values; a new job after reset yields the correct result.
